// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer.
// Multiplies by iterative shift-add and divides by iterative restoring division.
// Each normal operation takes 32 CALC cycles.
// Divide-by-zero and signed overflow bypass the iteration and finish after one cycle.
// Operands are converted to magnitudes on acceptance, and the result is sign-corrected on entry to FIN.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } state_t;

    // Two's complement negation helpers
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;

    // Operation context latched on acceptance
    logic [2:0]  f3_r;
    logic        a_neg_r;
    logic        b_neg_r;
    logic [31:0] opnd_r;     // multiplier / divisor magnitude
    logic [63:0] acc_r;      // mul: {partial high, multiplicand bits}; div: {remainder, quotient}
    logic [4:0]  cnt_r;

    // Input decode
    logic        signed_a_s;
    logic        signed_b_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        fast_div0_s;
    logic        fast_ovf_s;
    logic        fast_s;
    logic [31:0] fast_result_s;

    // Iteration and finalisation
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_next_s;
    logic [63:0] acc_next_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] final_result_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Decode operand signedness, magnitudes and fast-path cases from the live inputs
    always_comb begin
        signed_a_s    = 1'b0;
        signed_b_s    = 1'b0;
        fast_result_s = 32'd0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            F3_MULHSU: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        a_neg_s     = signed_a_s & op_a[31];
        b_neg_s     = signed_b_s & op_b[31];
        mag_a_s     = a_neg_s ? neg32(op_a) : op_a;
        mag_b_s     = b_neg_s ? neg32(op_b) : op_b;
        fast_div0_s = funct3[2] & (op_b == 32'd0);
        fast_ovf_s  = funct3[2] & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
        fast_s      = fast_div0_s | fast_ovf_s;
        case (funct3)
            F3_DIV, F3_DIVU: begin
                if (fast_div0_s) begin
                    fast_result_s = 32'hFFFF_FFFF;
                end else begin
                    fast_result_s = 32'h8000_0000;
                end
            end
            F3_REM, F3_REMU: begin
                if (fast_div0_s) begin
                    fast_result_s = op_a;
                end else begin
                    fast_result_s = 32'd0;
                end
            end
            default: fast_result_s = 32'd0;
        endcase
    end

    // One shift-add or restoring-divide step on the current accumulator
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        mul_next_s = {mul_sum_s, acc_r[31:1]};
        // A trial value of {rem, next dividend bit} is below 2*divisor, so bit 32 is the borrow
        div_diff_s = {acc_r[63:32], acc_r[31]} - {1'b0, opnd_r};
        if (div_diff_s[32]) begin
            div_next_s = {acc_r[62:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end
        if (f3_r[2]) begin
            acc_next_s = div_next_s;
        end else begin
            acc_next_s = mul_next_s;
        end
    end

    // Sign-correct the post-final-step accumulator and select the result
    always_comb begin
        if (a_neg_r ^ b_neg_r) begin
            prod_s = neg64(acc_next_s);
            quot_s = neg32(acc_next_s[31:0]);
        end else begin
            prod_s = acc_next_s;
            quot_s = acc_next_s[31:0];
        end
        if (a_neg_r) begin
            rem_s = neg32(acc_next_s[63:32]);
        end else begin
            rem_s = acc_next_s[63:32];
        end
        case (f3_r)
            F3_MUL:                        final_result_s = prod_s[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_result_s = prod_s[63:32];
            F3_DIV, F3_DIVU:               final_result_s = quot_s;
            F3_REM, F3_REMU:               final_result_s = rem_s;
            default:                       final_result_s = 32'd0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (fast_s) begin
                        state_s = FIN;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 5'd31) begin
                    state_s = FIN;
                end else begin
                    state_s = CALC;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; busy/done registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == CALC);
            done_r  <= (state_s == FIN);
        end
    end

    // Operation context, iteration datapath and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_r     <= 3'd0;
            a_neg_r  <= 1'b0;
            b_neg_r  <= 1'b0;
            opnd_r   <= 32'd0;
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
            result_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (fast_s) begin
                            result_r <= fast_result_s;
                        end else begin
                            f3_r    <= funct3;
                            a_neg_r <= a_neg_s;
                            b_neg_r <= b_neg_s;
                            opnd_r  <= mag_b_s;
                            acc_r   <= {32'd0, mag_a_s};
                            cnt_r   <= 5'd0;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        result_r <= final_result_s;
                    end
                end
                FIN: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 start  in  1  request strobe from decode, sampled only in IDLE.
REQ-005 funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  in  32  rs1 operand: multiplicand or dividend.
REQ-007 op_b  in  32  rs2 operand: multiplier or divisor.
REQ-008 busy  out  1  pipeline stall request, high while the operation is in progress.
REQ-009 done  out  1  one-cycle pulse: result valid.
REQ-010 result  out  32  final result, held until the next done.

Function
REQ-011 The block SHALL have states IDLE, CALC, FIN.
- IDLE->CALC: start=1, no fast-path case.
- IDLE->FIN: start=1, fast-path case.
- CALC->FIN: iteration counter = 31.
- FIN->IDLE: unconditional.
REQ-012 On the IDLE->CALC edge the block SHALL latch funct3, convert the operands to magnitudes, and latch the operand signs. Operands SHALL be treated as signed for MULH/DIV/REM; op_a signed and op_b unsigned for MULHSU; both unsigned otherwise. The 5-bit counter SHALL be set to 0.
REQ-013 Each CALC cycle SHALL perform exactly one iteration and increment the counter, for exactly 32 CALC cycles.
- Multiply: shift-add into a 64-bit accumulator.
- Divide: restoring step using a 33-bit subtractor; quotient and remainder each 32 bits.
REQ-014 On the CALC->FIN edge the block SHALL sign-correct and select the result.
- MUL: low 32 bits of the product.
- MULH, MULHSU, MULHU: high 32 bits of the product.
- Signed product is negated if the operand signs differ.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-015 The fast path SHALL produce results without iteration.
- Divide by zero (op_b=0): quotient 0xFFFFFFFF; remainder = op_a.
- Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): quotient 0x80000000; remainder 0.
REQ-016 busy SHALL be 1 in CALC and in the cycle after start is accepted, and 0 in IDLE and FIN.
REQ-017 done SHALL be 1 only in FIN, and result SHALL update on entry to FIN.
REQ-018 Latency SHALL be fixed.
- Normal path: start sampled at edge k gives done high in the cycle after edge k+33.
- Fast path: done high in the cycle after edge k+1.
REQ-019 start SHALL be ignored in CALC and FIN, with no queuing. start high in FIN is not accepted until the block has returned to IDLE.
REQ-020 Operand or funct3 changes after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-021 Reset SHALL asynchronously force the following: state IDLE, counter 0, busy 0, done 0, result 0x00000000, all internal registers cleared.
REQ-022 Reset asserted mid-CALC SHALL abort the operation with no done pulse. The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> result 0xFFFFFFEB; done exactly 33 cycles after start; busy high for 32 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 -> done one cycle after start; busy never high.
- start pulsed repeatedly during CALC with different operands -> ignored; the original result is returned; exactly one done pulse.
- reset asserted at CALC cycle 10 -> busy and done low and result 0 immediately; a subsequent DIVU 9/3 -> 3 with normal latency.
